btn_debounce: RTL and testbench
===============================

# btn_debounce

Debounces and qualifies a raw mechanical push-button input for the OrangeCrab user-IO path. It sits between the button pin and the LED/reset glue logic. It produces a clean level, single-cycle press and release events, a long-press indication and a one-shot active-low reset request. The reset request replaces the direct pin-to-`rst_n` wiring, so a brief bump of the button no longer resets the board.

## Interface
- `DEBOUNCE_CYCLES`, default 480000: consecutive stable cycles required to accept a level change (10 ms at 48 MHz).
- `LONG_CYCLES`, default 96000000: cycles of debounced hold before a long press (2 s).
- `RST_CYCLES`, default 4800: length of the `rst_req_n` low pulse (100 µs).
- `ACTIVE_LOW`, default 0: 1 means the pin reads 0 when pressed.
- `clk48`, in, 1: sole clock, 48 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_raw`, in, 1: asynchronous button pin.
- `btn_state`, out, 1: debounced level, 1 = pressed.
- `press_pulse`, out, 1: one-cycle strobe on a debounced press.
- `release_pulse`, out, 1: one-cycle strobe on a debounced release.
- `long_press`, out, 1: high from long-press detection until the debounced release.
- `rst_req_n`, out, 1: active-low reset request, one-shot per hold.
- `press_count`, out, 8: number of debounced presses, wraps 255→0.

## Operation
- **Input conditioning**
  - `btn_raw` passes through a 2-FF synchronizer.
  - It is then inverted if `ACTIVE_LOW`=1, giving `btn_s` (1 = pressed).
  - Synchronizer flops reset to the released level, so reset never creates a false press.
- **FSM states:** IDLE, PRESS_WAIT, HELD, REL_WAIT.
- **IDLE** (stable released)
  - `btn_s`=1 → PRESS_WAIT, debounce counter cleared.
- **PRESS_WAIT**
  - Counter increments each cycle while `btn_s`=1.
  - `btn_s`=0 on any cycle → IDLE. This is bounce rejection; no event is produced.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with `btn_s`=1 → HELD. Set `btn_state`, pulse `press_pulse`, increment `press_count`, clear the hold counter.
- **HELD**
  - Hold counter increments and saturates at `LONG_CYCLES`.
  - On the cycle the hold counter reaches `LONG_CYCLES`-1: set `long_press`, drive `rst_req_n` low for exactly `RST_CYCLES` cycles, then release it high.
  - The reset request fires at most once per hold.
  - `btn_s`=0 → REL_WAIT, debounce counter cleared.
- **REL_WAIT**
  - Counter increments while `btn_s`=0.
  - `btn_s`=1 → back to HELD. The hold counter, `long_press` and any running reset pulse are preserved, not restarted.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 → IDLE. Clear `btn_state` and `long_press`, pulse `release_pulse`.
- **Counter widths**
  - Debounce counter: $clog2(`DEBOUNCE_CYCLES`).
  - Hold counter: $clog2(`LONG_CYCLES`+1), saturating.
  - Reset pulse counter: $clog2(`RST_CYCLES`+1).
  - `press_count` is an unsigned 8-bit wrapping counter.
- **Release during the reset pulse**
  - The pulse completes its full `RST_CYCLES` length regardless of release.
  - `long_press` clears at the debounced release as normal.
- **Parameter legality**
  - `DEBOUNCE_CYCLES` ≥ 2, `LONG_CYCLES` > `DEBOUNCE_CYCLES`, `RST_CYCLES` ≥ 1.
  - Checked by elaboration assertion.

## Timing
- **Reset values:**
  - FSM: IDLE.
  - Counters: 0.
  - Outputs: `btn_state`=0, `press_pulse`=0, `release_pulse`=0, `long_press`=0, `rst_req_n`=1, `press_count`=0.
- **Reset mid-operation**
  - Asserting `rst` while HELD or during the reset pulse returns `rst_req_n` high on the next edge.
  - No release event is emitted.
- **Press latency:** `press_pulse` and `btn_state` rise 2 (synchronizer) + `DEBOUNCE_CYCLES` cycles after the first cycle of stable `btn_raw`.
- **Long-press latency:** `long_press` and the falling edge of `rst_req_n` occur `LONG_CYCLES` cycles after `press_pulse`.
- **Release latency:** `release_pulse` follows the same latency rule as press.
- **Output registering**
  - All outputs are registered; there is no combinational path from `btn_raw`.
  - `press_pulse` and `release_pulse` are never high in the same cycle and are each exactly 1 cycle wide.

## Structure
- **Package `btn_pkg`:** FSM state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT) and the default cycle constants at 48 MHz.
- **Sub-module `sync_2ff`:** 1-bit two-flop synchronizer with a reset-value parameter. It is reused for other asynchronous pins.
- **Remainder:** one FSM plus counters in `btn_debounce`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `RST_CYCLES`=3.

1. **Clean press:** `btn_raw` held 1 for 10 cycles → `press_pulse` high exactly 1 cycle, 6 cycles after the edge; `btn_state`=1; `press_count`=1.
2. **Bounce:** `btn_raw` toggles 1,0,1,0 every 2 cycles, then settles at 0 → no `press_pulse`, `btn_state` stays 0, `press_count`=0.
3. **Long press:** `btn_raw` held 30 cycles after acceptance.
   - `long_press` rises 20 cycles after `press_pulse`.
   - `rst_req_n` is low exactly 3 cycles, once.
   - Then release → `release_pulse` and `long_press`=0 on the same cycle.
4. **Release bounce during HELD:** a 2-cycle 0 glitch at hold cycle 10 → no `release_pulse`, and `long_press` still rises at hold cycle 20 (counter not restarted).
5. **Reset during pulse:** `rst` asserted on the 2nd low cycle of `rst_req_n` → next cycle `rst_req_n`=1, `btn_state`=0, `press_count`=0, no `release_pulse`.
6. **Wrap and polarity:** 256 clean presses → `press_count` wraps to 0. Repeat scenario 1 with `ACTIVE_LOW`=1 and the pin inverted → identical responses.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and 48 MHz default timings for the push-button debouncer.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } db_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 480_000;     // 10 ms
   localparam int DEF_LONG_CYCLES     = 96_000_000;  // 2 s
   localparam int DEF_RST_CYCLES      = 4_800;       // 100 us

   function automatic bit params_ok(input int debounce, input int long_cyc, input int rst_cyc);
      return (debounce >= 2) && (long_cyc > debounce) && (rst_cyc >= 1);
   endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin plus the qualified button outputs; master is the board side, slave the debouncer.
interface btn_debounce_if;

   logic       btn_raw;
   logic       btn_state;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_press;
   logic       rst_req_n;
   logic [7:0] press_count;

   modport master (
      output btn_raw,
      input  btn_state,
      input  press_pulse,
      input  release_pulse,
      input  long_press,
      input  rst_req_n,
      input  press_count
   );

   modport slave (
      input  btn_raw,
      output btn_state,
      output press_pulse,
      output release_pulse,
      output long_press,
      output rst_req_n,
      output press_count
   );

endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous pins; RST_VAL sets the idle level.
module sync_2ff #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: clean level, press/release strobes, long-press flag and
// a one-shot active-low reset request per long hold.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | button stably released
//   PRESS_WAIT | button seen pressed, counting stable cycles before accepting
//   HELD       | press accepted, hold timer running
//   REL_WAIT   | button seen released, counting stable cycles before accepting
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int RST_CYCLES      = DEF_RST_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input logic           clk48,
   input logic           rst,
   btn_debounce_if.slave bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
   localparam logic [RW-1:0] RST_LOAD  = RW'(RST_CYCLES);

   if (!params_ok(DEBOUNCE_CYCLES, LONG_CYCLES, RST_CYCLES)) begin : g_param_check
      $error("btn_debounce: need DEBOUNCE_CYCLES>=2, LONG_CYCLES>DEBOUNCE_CYCLES, RST_CYCLES>=1");
   end

   db_state_t     state;
   db_state_t     state_nxt;
   logic          btn_sync;
   logic          btn_s;
   logic [DW-1:0] db_cnt;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] rst_cnt;
   logic          db_done;
   logic          hold_run;
   logic          press_evt;
   logic          release_evt;
   logic          long_evt;

   logic          btn_state_q;
   logic          press_pulse_q;
   logic          release_pulse_q;
   logic          long_press_q;
   logic          rst_req_n_q;
   logic [7:0]    press_count_q;

   // Flops idle at the released pin level so leaving reset never looks like a press.
   sync_2ff #(
      .RST_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk_sys (clk48),
      .rst     (rst),
      .d       (bus.btn_raw),
      .q       (btn_sync)
   );

   assign btn_s   = btn_sync ^ ACTIVE_LOW;
   assign db_done = (db_cnt == DB_LAST);

   always_ff @(posedge clk48) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (btn_s) state_nxt = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!btn_s)       state_nxt = IDLE;
            else if (db_done) state_nxt = HELD;
         end
         HELD: begin
            if (!btn_s) state_nxt = REL_WAIT;
         end
         REL_WAIT: begin
            if (btn_s)        state_nxt = HELD;
            else if (db_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Hold timer keeps running through a release glitch so the long-press point does not move.
   always_comb begin
      press_evt   = 1'b0;
      release_evt = 1'b0;
      hold_run    = 1'b0;
      long_evt    = 1'b0;
      unique case (state)
         PRESS_WAIT: press_evt = btn_s && db_done;
         HELD:       hold_run  = 1'b1;
         REL_WAIT: begin
            hold_run    = 1'b1;
            release_evt = !btn_s && db_done;
         end
         default: ;
      endcase
      long_evt = hold_run && (hold_cnt == HOLD_LAST) && !release_evt;
   end

   always_ff @(posedge clk48) begin
      if (rst) begin
         db_cnt          <= '0;
         hold_cnt        <= '0;
         rst_cnt         <= '0;
         btn_state_q     <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_press_q    <= 1'b0;
         rst_req_n_q     <= 1'b1;
         press_count_q   <= 8'd0;
      end else begin
         press_pulse_q   <= press_evt;
         release_pulse_q <= release_evt;

         if (state == PRESS_WAIT || state == REL_WAIT) begin
            db_cnt <= db_cnt + 1'b1;
         end else begin
            db_cnt <= '0;
         end

         if (press_evt) begin
            hold_cnt <= '0;
         end else if (hold_run && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         if (press_evt) begin
            btn_state_q   <= 1'b1;
            press_count_q <= press_count_q + 8'd1;
         end else if (release_evt) begin
            btn_state_q <= 1'b0;
         end

         if (release_evt) begin
            long_press_q <= 1'b0;
         end else if (long_evt) begin
            long_press_q <= 1'b1;
         end

         // Reset request is a down-counter; it runs to completion even across a release.
         if (long_evt) begin
            rst_cnt     <= RST_LOAD;
            rst_req_n_q <= 1'b0;
         end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
            if (rst_cnt == RW'(1)) rst_req_n_q <= 1'b1;
         end
      end
   end

   assign bus.btn_state     = btn_state_q;
   assign bus.press_pulse   = press_pulse_q;
   assign bus.release_pulse = release_pulse_q;
   assign bus.long_press    = long_press_q;
   assign bus.rst_req_n     = rst_req_n_q;
   assign bus.press_count   = press_count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench: one active-high and one active-low debouncer driven with mirrored pins.
module tb_btn_debounce;

   logic clk48 = 1'b0;
   logic rst;
   logic btn;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int np[2], nr[2], nlow[2], nfall[2], nboth[2];
   int press_cyc[2], rel_cyc[2], lrise_cyc[2], lfall_cyc[2], rfall_cyc[2];
   logic lp_prev[2], rn_prev[2];

   btn_debounce_if bus0 ();
   btn_debounce_if bus1 ();

   btn_debounce #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20),
      .RST_CYCLES      (3),
      .ACTIVE_LOW      (1'b0)
   ) dut_ah (
      .clk48 (clk48),
      .rst   (rst),
      .bus   (bus0)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20),
      .RST_CYCLES      (3),
      .ACTIVE_LOW      (1'b1)
   ) dut_al (
      .clk48 (clk48),
      .rst   (rst),
      .bus   (bus1)
   );

   always #5 clk48 = ~clk48;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk2(input string tag, input int got_ah, input int got_al, input int exp);
      chk({tag, "/ah"}, got_ah, exp);
      chk({tag, "/al"}, got_al, exp);
   endtask

   task automatic set_btn(input logic v);
      btn          = v;
      bus0.btn_raw = v;
      bus1.btn_raw = ~v;
   endtask

   task automatic clr();
      for (int d = 0; d < 2; d++) begin
         np[d] = 0; nr[d] = 0; nlow[d] = 0; nfall[d] = 0; nboth[d] = 0;
         press_cyc[d] = -1; rel_cyc[d] = -1; lrise_cyc[d] = -1;
         lfall_cyc[d] = -1; rfall_cyc[d] = -1;
      end
      lp_prev[0] = bus0.long_press; lp_prev[1] = bus1.long_press;
      rn_prev[0] = bus0.rst_req_n;  rn_prev[1] = bus1.rst_req_n;
   endtask

   task automatic step();
      logic [1:0] pp, rp, lp, rn;
      @(posedge clk48);
      #1;
      cyc++;
      pp = {bus1.press_pulse, bus0.press_pulse};
      rp = {bus1.release_pulse, bus0.release_pulse};
      lp = {bus1.long_press, bus0.long_press};
      rn = {bus1.rst_req_n, bus0.rst_req_n};
      for (int d = 0; d < 2; d++) begin
         if (pp[d] === 1'b1) begin np[d]++; press_cyc[d] = cyc; end
         if (rp[d] === 1'b1) begin nr[d]++; rel_cyc[d] = cyc; end
         if (pp[d] === 1'b1 && rp[d] === 1'b1) nboth[d]++;
         if (lp[d] === 1'b1 && lp_prev[d] === 1'b0) lrise_cyc[d] = cyc;
         if (lp[d] === 1'b0 && lp_prev[d] === 1'b1) lfall_cyc[d] = cyc;
         if (rn[d] === 1'b0) nlow[d]++;
         if (rn[d] === 1'b0 && rn_prev[d] === 1'b1) begin nfall[d]++; rfall_cyc[d] = cyc; end
         lp_prev[d] = lp[d];
         rn_prev[d] = rn[d];
      end
   endtask

   task automatic hold(input logic v, input int n);
      set_btn(v);
      repeat (n) step();
   endtask

   initial begin
      int t0;
      bit found;

      rst = 1'b1;
      set_btn(1'b0);
      repeat (3) step();
      chk2("rst_btn_state", bus0.btn_state, bus1.btn_state, 0);
      chk2("rst_press_pulse", bus0.press_pulse, bus1.press_pulse, 0);
      chk2("rst_release_pulse", bus0.release_pulse, bus1.release_pulse, 0);
      chk2("rst_long_press", bus0.long_press, bus1.long_press, 0);
      chk2("rst_rst_req_n", bus0.rst_req_n, bus1.rst_req_n, 1);
      chk2("rst_press_count", bus0.press_count, bus1.press_count, 0);
      rst = 1'b0;

      // bounce: 1,1,0,0,1,1,0,0 then settled released
      clr();
      hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
      hold(1'b0, 10);
      chk2("bounce_presses", np[0], np[1], 0);
      chk2("bounce_btn_state", bus0.btn_state, bus1.btn_state, 0);
      chk2("bounce_press_count", bus0.press_count, bus1.press_count, 0);

      // clean press: pulse 6 cycles after the first sampled edge
      clr();
      t0 = cyc + 1;
      hold(1'b1, 10);
      chk2("press_pulses", np[0], np[1], 1);
      chk2("press_latency", press_cyc[0] - t0, press_cyc[1] - t0, 6);
      chk2("press_btn_state", bus0.btn_state, bus1.btn_state, 1);
      chk2("press_count_1", bus0.press_count, bus1.press_count, 1);
      clr();
      t0 = cyc + 1;
      hold(1'b0, 10);
      chk2("release_pulses", nr[0], nr[1], 1);
      chk2("release_latency", rel_cyc[0] - t0, rel_cyc[1] - t0, 6);
      chk2("release_btn_state", bus0.btn_state, bus1.btn_state, 0);
      chk2("short_no_rst_req", nlow[0], nlow[1], 0);

      // long press: held 30 cycles beyond acceptance
      clr();
      t0 = cyc + 1;
      hold(1'b1, 37);
      chk2("long_press_latency", press_cyc[0] - t0, press_cyc[1] - t0, 6);
      chk2("long_rise_after_press", lrise_cyc[0] - press_cyc[0], lrise_cyc[1] - press_cyc[1], 20);
      chk2("rst_fall_with_long", rfall_cyc[0] - lrise_cyc[0], rfall_cyc[1] - lrise_cyc[1], 0);
      chk2("rst_low_cycles", nlow[0], nlow[1], 3);
      chk2("rst_one_shot", nfall[0], nfall[1], 1);
      chk2("long_level", bus0.long_press, bus1.long_press, 1);
      clr();
      t0 = cyc + 1;
      hold(1'b0, 10);
      chk2("long_release_pulses", nr[0], nr[1], 1);
      chk2("long_release_latency", rel_cyc[0] - t0, rel_cyc[1] - t0, 6);
      chk2("long_clear_at_release", lfall_cyc[0] - rel_cyc[0], lfall_cyc[1] - rel_cyc[1], 0);

      // release glitch of 2 cycles around hold cycle 10
      clr();
      t0 = cyc + 1;
      hold(1'b1, 15);
      hold(1'b0, 2);
      hold(1'b1, 25);
      chk2("glitch_press_latency", press_cyc[0] - t0, press_cyc[1] - t0, 6);
      chk2("glitch_no_release", nr[0], nr[1], 0);
      chk2("glitch_long_at_20", lrise_cyc[0] - press_cyc[0], lrise_cyc[1] - press_cyc[1], 20);
      chk2("glitch_btn_state", bus0.btn_state, bus1.btn_state, 1);
      chk2("glitch_rst_low_cycles", nlow[0], nlow[1], 3);
      clr();
      hold(1'b0, 10);
      chk2("glitch_final_release", nr[0], nr[1], 1);

      // reset on the second low cycle of rst_req_n
      clr();
      set_btn(1'b1);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (bus0.rst_req_n === 1'b0) found = 1'b1;
      end
      chk("midrst_pulse_seen", int'(found), 1);
      step();
      chk2("midrst_second_low", bus0.rst_req_n, bus1.rst_req_n, 0);
      rst = 1'b1;
      set_btn(1'b0);
      clr();
      step();
      chk2("midrst_rst_req_n", bus0.rst_req_n, bus1.rst_req_n, 1);
      chk2("midrst_btn_state", bus0.btn_state, bus1.btn_state, 0);
      chk2("midrst_press_count", bus0.press_count, bus1.press_count, 0);
      chk2("midrst_release_pulse", bus0.release_pulse, bus1.release_pulse, 0);
      rst = 1'b0;
      hold(1'b0, 10);
      chk2("midrst_no_release_after", nr[0], nr[1], 0);
      chk2("midrst_no_press_after", np[0], np[1], 0);

      // press_count wrap
      clr();
      for (int i = 0; i < 255; i++) begin
         hold(1'b1, 8);
         hold(1'b0, 8);
      end
      chk2("count_255", bus0.press_count, bus1.press_count, 255);
      hold(1'b1, 8);
      hold(1'b0, 8);
      chk2("count_wrap_0", bus0.press_count, bus1.press_count, 0);
      chk2("wrap_presses", np[0], np[1], 256);
      chk2("wrap_releases", nr[0], nr[1], 256);
      chk2("pulses_never_overlap", nboth[0], nboth[1], 0);
      chk2("wrap_no_long", nlow[0], nlow[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
